// File: rtl/icache_fetch_if.sv
// Word-wide instruction memory bus between icache_fetch and the instruction memory.
//   mem_req    : word read request (cache -> memory), held until granted
//   mem_addr   : word-aligned request address (cache -> memory)
//   mem_gnt    : request accepted this cycle (memory -> cache)
//   mem_rvalid : read data valid (memory -> cache)
//   mem_rdata  : read data (memory -> cache)
interface icache_fetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache for a single-cycle rv32 core.
// Hits return the word combinationally; a miss stalls the core and refills the
// whole line in ascending word order, one outstanding memory request at a time.
//   clk    : clock, all state on the rising edge
//   reset  : synchronous active-low reset
//   pc     : fetch address (bits [1:0] ignored), held by the core while stall=1
//   flush  : invalidate all lines
//   instr  : instruction to the core (NOP while stalled)
//   stall  : 1 = instruction not available
//   mem    : memory bus (master side)
module icache_fetch #(
    parameter int unsigned NLINES     = 16,
    parameter int unsigned LINE_WORDS = 4,
    parameter logic [31:0] NOP        = 32'h00000013
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   pc,
    input  logic          flush,
    output logic [31:0]   instr,
    output logic          stall,
    icache_fetch_if.master mem
);

    localparam int unsigned OFF   = $clog2(LINE_WORDS);
    localparam int unsigned IDX   = $clog2(NLINES);
    localparam int unsigned TAGW  = 32 - OFF - IDX - 2;
    localparam int unsigned LINEW = 30 - OFF;  // tag + index of a line base
    localparam logic [OFF-1:0] LAST = OFF'(LINE_WORDS - 1);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e             state_q, state_d;
    logic [LINEW-1:0]   line_q, line_d;
    logic [OFF-1:0]     rq_q, rq_d;
    logic [OFF-1:0]     rs_q, rs_d;
    logic               pend_q, pend_d;
    logic [NLINES-1:0]  valid_q, valid_d;

    logic [31:0]        data_q [NLINES*LINE_WORDS];
    logic [TAGW-1:0]    tag_q  [NLINES];

    logic [OFF-1:0]     pc_off;
    logic [IDX-1:0]     pc_idx;
    logic [TAGW-1:0]    pc_tag;
    logic [IDX-1:0]     fill_idx;
    logic [TAGW-1:0]    fill_tag;
    logic               hit, rvalid_ok, wr_en, fill_done;
    logic               unused_pc_bits;

    assign pc_off   = pc[OFF+1:2];
    assign pc_idx   = pc[OFF+IDX+1:OFF+2];
    assign pc_tag   = pc[31:OFF+IDX+2];
    assign fill_idx = line_q[IDX-1:0];
    assign fill_tag = line_q[LINEW-1:IDX];
    assign unused_pc_bits = ^pc[1:0];

    assign hit   = (state_q == StIdle) & valid_q[pc_idx] & (tag_q[pc_idx] == pc_tag);
    assign stall = ~hit | ~reset;
    assign instr = stall ? NOP : data_q[{pc_idx, pc_off}];

    // Reset gating keeps the bus quiet while reset is held, even before the first edge.
    assign mem.mem_req  = (state_q == StReq) & ~pend_q & reset;
    assign mem.mem_addr = reset ? {line_q, rq_q, 2'b00} : 32'h0;

    // Responses only count while a request is outstanding; stale ones after reset are dropped.
    assign rvalid_ok = (state_q != StIdle) & pend_q & mem.mem_rvalid;
    assign wr_en     = rvalid_ok & reset;
    assign fill_done = wr_en & (rs_q == LAST);

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        rq_d    = rq_q;
        rs_d    = rs_q;
        pend_d  = pend_q;
        // Flush first so a coinciding line completion still ends valid.
        valid_d = flush ? '0 : valid_q;

        unique case (state_q)
            StIdle: begin
                if (!hit) begin
                    line_d  = pc[31:OFF+2];
                    rq_d    = '0;
                    rs_d    = '0;
                    pend_d  = 1'b0;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (mem.mem_req && mem.mem_gnt) begin
                    rq_d   = rq_q + OFF'(1);
                    pend_d = 1'b1;
                    if (rq_q == LAST) begin
                        state_d = StWait;
                    end
                end
            end
            StWait: ;
            default: state_d = StIdle;
        endcase

        // A grant needs pend=0 and a response needs pend=1, so these never collide.
        if (rvalid_ok) begin
            rs_d   = rs_q + OFF'(1);
            pend_d = 1'b0;
            if (rs_q == LAST) begin
                valid_d[fill_idx] = 1'b1;
                state_d           = StIdle;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            line_q  <= '0;
            rq_q    <= '0;
            rs_q    <= '0;
            pend_q  <= 1'b0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            rq_q    <= rq_d;
            rs_q    <= rs_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
        end
    end

    // Data and tag arrays carry no reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[{fill_idx, rs_q}] <= mem.mem_rdata;
        end
        if (fill_done) begin
            tag_q[fill_idx] <= fill_tag;
        end
    end

endmodule

// File: tb/tb_icache_fetch.sv
module tb_icache_fetch;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        flush;
    logic [31:0] instr;
    logic        stall;

    icache_fetch_if mif ();

    icache_fetch #(
        .NLINES     (16),
        .LINE_WORDS (4),
        .NOP        (NOP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pc    (pc),
        .flush (flush),
        .instr (instr),
        .stall (stall),
        .mem   (mif)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Memory behaviour knobs.
    int gnt_max = 0;
    int rv_min  = 0;
    int rv_max  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Memory: grants after 0..gnt_max cycles, answers rv_min..rv_max cycles after the grant.
    initial begin
        bit          prev_x;
        logic [31:0] prev_a;
        bit          rbusy;
        logic [31:0] raddr;
        int          rcnt;
        int          gcnt;
        prev_x = 0; prev_a = 0; rbusy = 0; raddr = 0; rcnt = 0; gcnt = 0;
        mif.mem_gnt = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (prev_x) begin
                rbusy = 1;
                raddr = prev_a;
                rcnt  = $urandom_range(rv_max, rv_min);
            end
            mif.mem_rvalid = 1'b0;
            mif.mem_rdata  = $urandom;
            if (rbusy) begin
                if (rcnt == 0) begin
                    mif.mem_rvalid = 1'b1;
                    mif.mem_rdata  = memf(raddr);
                    rbusy          = 0;
                end else begin
                    rcnt--;
                end
            end
            if (mif.mem_req) begin
                if (gcnt == 0) begin
                    mif.mem_gnt = 1'b1;
                    gcnt        = $urandom_range(gnt_max, 0);
                end else begin
                    mif.mem_gnt = 1'b0;
                    gcnt--;
                end
            end else begin
                mif.mem_gnt = 1'b0;
            end
            prev_x = mif.mem_req && mif.mem_gnt;
            prev_a = mif.mem_addr;
        end
    end

    // Reference model: line-level cache contents plus a count-based view of the refill.
    bit          m_valid [16];
    int unsigned m_tag   [16];
    bit          m_busy  = 0;
    bit          m_pend  = 0;
    int          m_grants = 0;
    int          m_resps  = 0;
    logic [31:0] m_base   = 0;
    int          dg       = 0;

    initial begin
        bit          e_req, e_stall, m_hit, xfer, rv;
        logic [31:0] e_instr;
        int unsigned idx, tg, fidx;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_tag[i]   = 0;
        end
        @(posedge clk);
        forever begin
            @(negedge clk);
            #2;
            idx     = (pc >> 4) & 15;
            tg      = pc >> 8;
            m_hit   = !m_busy && m_valid[idx] && (m_tag[idx] == tg);
            e_stall = !reset || !m_hit;
            e_instr = e_stall ? NOP : memf(pc & ~32'h3);
            e_req   = reset && m_busy && !m_pend && (m_grants < 4);
            chk("stall", stall, e_stall);
            chk("instr", instr, e_instr);
            chk("mem_req", mif.mem_req, e_req);
            if (e_req) chk("mem_addr", mif.mem_addr, m_base + 4 * m_grants);
            else if (!reset) chk("mem_addr_reset", mif.mem_addr, 32'h0);

            // Advance the model across the coming edge.
            if (!reset) begin
                m_busy = 0; m_pend = 0; m_grants = 0; m_resps = 0; dg = 0;
                for (int i = 0; i < 16; i++) m_valid[i] = 0;
            end else begin
                if (mif.mem_req && mif.mem_gnt) dg++;
                xfer = e_req && mif.mem_gnt;
                rv   = m_busy && m_pend && mif.mem_rvalid;
                fidx = (m_base >> 4) & 15;
                if (flush) for (int i = 0; i < 16; i++) m_valid[i] = 0;
                if (!m_busy) begin
                    if (!m_hit) begin
                        m_busy = 1; m_pend = 0; m_grants = 0; m_resps = 0; dg = 0;
                        m_base = pc & ~32'hF;
                    end
                end else begin
                    if (xfer) begin
                        m_grants++;
                        m_pend = 1;
                    end
                    if (rv) begin
                        m_resps++;
                        m_pend = 0;
                        if (m_resps == 4) begin
                            m_valid[fidx] = 1;
                            m_tag[fidx]   = m_base >> 8;
                            m_busy        = 0;
                            chk("grants_per_fill", dg, 4);
                        end
                    end
                end
            end
        end
    end

    // Inputs change at posedge+1; observations at posedge+7.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic obs();
        #6;
    endtask

    // Called at the observation point; waits for a hit with a bounded budget.
    task automatic wait_hit(input string nm);
        int n;
        n = 0;
        while (stall && n < 200) begin
            next();
            obs();
            n++;
        end
        chk(nm, stall, 1'b0);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] t, i, w, b;
        t = $urandom_range(2, 0);
        i = $urandom_range(3, 0);
        w = $urandom_range(3, 0);
        b = $urandom_range(3, 0);
        return (t << 8) | (i << 4) | (w << 2) | b;
    endfunction

    initial begin
        logic [31:0] hit_pc  [4];
        logic [31:0] hit_exp [4];
        int          n;
        bit          last_stall;
        hit_pc  = '{32'h4, 32'h8, 32'hC, 32'h6};
        hit_exp = '{32'hA5A5_0004, 32'hA5A5_0008, 32'hA5A5_000C, 32'hA5A5_0004};

        reset = 1'b0; pc = 32'h0; flush = 1'b0;
        repeat (3) next();
        obs();
        chk("rst_stall", stall, 1'b1);
        chk("rst_instr", instr, NOP);
        chk("rst_req", mif.mem_req, 1'b0);
        chk("rst_addr", mif.mem_addr, 32'h0);

        // First miss with an always-granting, next-cycle memory: cycle-exact.
        next();
        reset = 1'b1; pc = 32'h0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) next();
            obs();
            if (c == 0) begin
                chk("miss_stall", stall, 1'b1);
            end else if (c < 9) begin
                if (c % 2 == 1) begin
                    chk("seq_req", mif.mem_req, 1'b1);
                    chk("seq_addr", mif.mem_addr, 32'((c - 1) * 2));
                end else begin
                    chk("seq_req_gap", mif.mem_req, 1'b0);
                end
            end else begin
                chk("fill_c9_stall", stall, 1'b0);
                chk("fill_c9_instr", instr, 32'hA5A5_0000);
            end
        end

        for (int k = 0; k < 4; k++) begin
            next();
            pc = hit_pc[k];
            obs();
            chk("line0_hit_stall", stall, 1'b0);
            chk("line0_hit_instr", instr, hit_exp[k]);
        end

        // Same index, different tag.
        next(); pc = 32'h100; obs();
        chk("conflict_miss", stall, 1'b1);
        wait_hit("conflict_fill");
        chk("conflict_instr", instr, 32'hA5A5_0100);
        next(); pc = 32'h0; obs();
        chk("conflict_back_miss", stall, 1'b1);
        wait_hit("conflict_back_fill");

        // Flush while idle.
        next(); pc = 32'h10; obs();
        wait_hit("line1_fill");
        next(); flush = 1'b1; obs();
        chk("flush_cycle_hit", stall, 1'b0);
        next(); flush = 1'b0; pc = 32'h0; obs();
        chk("flush_l0_miss", stall, 1'b1);
        wait_hit("flush_l0_fill");
        next(); pc = 32'h10; obs();
        chk("flush_l1_miss", stall, 1'b1);
        wait_hit("flush_l1_fill");

        // Flush coincident with the final rvalid (cycle 8).
        next(); pc = 32'h20; obs();
        chk("l2_miss", stall, 1'b1);
        for (int c = 1; c <= 8; c++) begin
            next();
            flush = (c == 8);
        end
        next(); flush = 1'b0; obs();
        chk("flush_fill_hit", stall, 1'b0);
        chk("flush_fill_instr", instr, 32'hA5A5_0020);
        next(); pc = 32'h10; obs();
        chk("flush_fill_other", stall, 1'b1);
        wait_hit("other_refill");

        // Reset during the third word; its response lands after reset is released.
        rv_min = 3; rv_max = 3;
        next(); pc = 32'h0; obs();
        n = 0;
        while (!(mif.mem_req && mif.mem_addr == 32'h8) && n < 50) begin
            next(); obs(); n++;
        end
        chk("word2_req_seen", mif.mem_addr, 32'h8);
        next(); reset = 1'b0;
        next();
        next();
        next(); reset = 1'b1; obs();
        chk("post_reset_miss", stall, 1'b1);
        n = 0;
        while (!mif.mem_req && n < 50) begin
            next(); obs(); n++;
        end
        chk("restart_req", mif.mem_req, 1'b1);
        chk("restart_addr", mif.mem_addr, 32'h0);
        wait_hit("restart_fill");
        chk("restart_instr", instr, 32'hA5A5_0000);

        // Randomized traffic with random bus delays and occasional flushes.
        gnt_max = 5; rv_min = 0; rv_max = 5;
        last_stall = 1;
        for (int i = 0; i < 2500; i++) begin
            next();
            if (!last_stall) pc = rand_pc();
            flush = ($urandom_range(15, 0) == 0);
            obs();
            last_stall = stall;
        end
        next(); flush = 1'b0;
        repeat (2) next();
        obs();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
